// File: rtl/addsub_pkg.sv
// Shared sizing for the pipelined adder/subtractor.
// Module parameters default to these values.
package addsub_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;
    localparam int CHUNK_DEF  = WIDTH_DEF / STAGES_DEF;

endpackage

// File: rtl/add_stage.sv
// One CHUNK-bit slice of the ripple: sum, carry out, and
// the carry into its top bit for signed overflow detection.
module add_stage
    import addsub_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum     = full[CHUNK-1:0];
    assign cout    = full[CHUNK];
    // a^b^sum at a bit position recovers the carry that entered it
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-chained add/sub, one CHUNK slice per stage, with a
// global stall when the output beat is held by downstream.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              ovf_q, ovf_d;

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] cin_s;
    logic [STAGES-1:0] cout_s;
    logic [STAGES-1:0] msbc_s;
    logic [WIDTH-1:0]  a_s [STAGES];
    logic [WIDTH-1:0]  b_s [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [CHUNK-1:0]  sum_s [STAGES];

    logic stall;

    assign stall       = vld_q[STAGES-1] && !out_ready;
    assign in_ready    = !stall;
    assign out_valid   = vld_q[STAGES-1];
    assign data_result = r_q[STAGES-1];
    assign carry_out   = cy_q[STAGES-1];
    assign overflow    = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // subtraction enters as A + ~B with carry-in 1
            assign vld_s[k] = in_valid;
            assign a_s[k]   = data_operandA;
            assign b_s[k]   = ctrl_sub ? ~data_operandB : data_operandB;
            assign r_s[k]   = '0;
            assign cin_s[k] = ctrl_sub;
        end else begin : g_body
            assign vld_s[k] = vld_q[k-1];
            assign a_s[k]   = a_q[k-1];
            assign b_s[k]   = b_q[k-1];
            assign r_s[k]   = r_q[k-1];
            assign cin_s[k] = cy_q[k-1];
        end

        add_stage #(
            .CHUNK(CHUNK)
        ) u_add (
            .a       (a_s[k][k*CHUNK +: CHUNK]),
            .b       (b_s[k][k*CHUNK +: CHUNK]),
            .cin     (cin_s[k]),
            .sum     (sum_s[k]),
            .cout    (cout_s[k]),
            .msb_cin (msbc_s[k])
        );
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        ovf_d = ovf_q;
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = vld_s[k];
                cy_d[k]  = cout_s[k];
                a_d[k]   = a_s[k];
                b_d[k]   = b_s[k];
                r_d[k]   = r_s[k];
                r_d[k][k*CHUNK +: CHUNK] = sum_s[k];
            end
            ovf_d = cout_s[STAGES-1] ^ msbc_s[STAGES-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: latency, arithmetic
// corner cases, streaming, backpressure and mid-stream reset.
module tb_pipelined_addsub;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        carry_out;
    logic        overflow;

    int tests;
    int fails;

    pipelined_addsub dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_sub      (ctrl_sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .carry_out     (carry_out),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one isolated beat: latency counted in cycles after the accepting edge
    task automatic run_one(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic sub,
                           input logic [31:0] er, input logic ec,
                           input logic eo);
        int lat;
        @(negedge clock);
        in_valid      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        ctrl_sub      = sub;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_result"}, 64'(data_result), 64'(er));
        check({tag, "_carry"}, 64'(carry_out), 64'(ec));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        logic [31:0] one;
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic [31:0] held;
        logic        held_ok;
        int          sent;
        int          recv;
        int          stray;

        tests         = 0;
        fails         = 0;
        one           = 32'd1;
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_sub      = 1'b0;
        out_ready     = 1'b1;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        run_one("zero", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_one("max_pos", 32'h7FFF_FFFF, 32'h1, 1'b0,
                32'h8000_0000, 1'b0, 1'b1);
        run_one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0,
                32'h0, 1'b1, 1'b0);
        run_one("sub_5_3", 32'd5, 32'd3, 1'b1, 32'h2, 1'b1, 1'b0);
        run_one("sub_0_1", 32'd0, 32'd1, 1'b1,
                32'hFFFF_FFFF, 1'b0, 1'b0);
        run_one("sub_min", 32'h8000_0000, 32'd1, 1'b1,
                32'h7FFF_FFFF, 1'b1, 1'b1);

        // back-to-back stream of powers of two
        for (int c = 0; c < 35; c++) begin
            @(negedge clock);
            if (c >= 4) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_result", 64'(data_result),
                      64'(one << (c - 3)));
            end
            if (c < 31) begin
                in_valid      = 1'b1;
                data_operandA = one << c;
                data_operandB = one << c;
                ctrl_sub      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clock);
        check("stream_drained", 64'(out_valid), 64'd0);

        // 8 beats with downstream refusing for three cycles
        for (int i = 0; i < 8; i++) begin
            sa[i] = 32'h0101_0101 * i;
            sb[i] = 32'h10 + i;
        end
        sent    = 0;
        recv    = 0;
        held    = '0;
        held_ok = 1'b0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clock);
            out_ready = !(c >= 6 && c <= 8);
            #1;
            if (out_valid) begin
                check("stall_result", 64'(data_result),
                      64'(sa[recv] + sb[recv]));
                if (held_ok)
                    check("stall_hold", 64'(data_result), 64'(held));
                if (!out_ready) begin
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    held    = data_result;
                    held_ok = 1'b1;
                end else begin
                    held_ok = 1'b0;
                    recv++;
                end
            end
            if (sent < 8) begin
                in_valid      = 1'b1;
                data_operandA = sa[sent];
                data_operandB = sb[sent];
                ctrl_sub      = 1'b0;
                if (in_ready)
                    sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_count", 64'(recv), 64'd8);

        // three beats in flight, then reset pulse
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid      = 1'b1;
            data_operandA = 32'h1111_1111 * (i + 1);
            data_operandB = 32'h2222_2222;
            ctrl_sub      = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_result", 64'(data_result), 64'h3333_3333);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(data_result), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid)
                stray++;
        end
        check("rst_no_stray", 64'(stray), 64'd0);
        run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0,
                32'h2345_6789, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
